exception_vector_fetch: RTL and testbench
=========================================

// Module: exception_vector_fetch
// PURPOSE
//   Consumer side of the memory-address exception path. On an exception it:
//     - saves EPC;
//     - drives the memory-address mux select to vector byte 253/254/255;
//     - waits the memory read latency;
//     - loads the zero-extended handler byte into PC.
//   Sits between the control FSM, the address mux selector, memory read data and the PC/EPC registers.
// PARAMETERS
//   MEM_LATENCY  2  cycles address must be held before mem_data is sampled (legal 1..15)
//   EPC_OFFSET   4  subtracted from pc_in to form EPC (pc_in is already PC+4)
// PORTS
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-low reset (0 = reset)
//   exc_req        in   1   exception request, one-cycle or level; sampled only in IDLE
//   exc_cause      in   2   0=opcode inexistente, 1=overflow, 2=div by zero, 3=reserved
//   pc_in          in   32  current PC value (PC+4 of faulting instruction)
//   mem_data       in   32  memory read data; handler address in bits [7:0]
//   addr_sel       out  3   address mux select: 3'b100=253, 3'b101=254, 3'b110=255
//   addr_sel_valid out  1   1 = control must route addr_sel to the address mux and hold mem write off
//   epc_out        out  32  value to write to EPC
//   epc_wr         out  1   EPC write strobe, one cycle
//   pc_out         out  32  handler address {24'b0, mem_data[7:0]}
//   pc_wr          out  1   PC write strobe, one cycle
//   busy           out  1   state != IDLE
//   done           out  1   one-cycle pulse, coincident with pc_wr
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (async, immediate) values: state=IDLE, all outputs 0, counter 0.
//     Reset mid-operation aborts with no pc_wr/epc_wr.
//   - States: IDLE, ADDR, COMMIT.
//   - IDLE:
//       - edge with exc_req=1 and exc_cause!=3 -> ADDR. At that edge:
//           - latch cause; cnt <= MEM_LATENCY-1;
//           - epc_out <= pc_in - EPC_OFFSET (mod 2^32, wraps); epc_wr <= 1;
//           - addr_sel <= 100/101/110 for cause 0/1/2; addr_sel_valid <= 1.
//       - exc_cause=3: request ignored, stay IDLE, no strobes.
//   - ADDR:
//       - addr_sel, addr_sel_valid held; epc_wr is high only in the first ADDR cycle.
//       - cnt!=0: cnt--.
//       - cnt==0: at that edge pc_out <= {24'b0, mem_data[7:0]}; pc_wr <= 1; done <= 1;
//         addr_sel_valid <= 0; addr_sel <= 0 -> COMMIT.
//   - COMMIT:
//       - pc_wr=done=1 for exactly this cycle; next edge -> IDLE, strobes cleared.
//       - pc_out and epc_out keep their values until the next exception.
//   - Latency: request edge E0; addr_sel_valid high for MEM_LATENCY cycles; pc_wr high in
//     cycle MEM_LATENCY+1 after E0. Back-to-back requests are accepted no sooner than the IDLE cycle after COMMIT.
//   - exc_req while busy: ignored, not queued. Changes to cause or pc_in while busy: no effect.
//   - mem_data is sampled only at the final ADDR edge; it is don't-care at all other times.
// TESTING
//   1. Hold reset=0, then release -> all outputs 0, busy=0. Assert reset mid-ADDR -> outputs 0 immediately, no pc_wr.
//   2. Overflow: pc_in=0x40, cause=1, mem_data=0x0000_0080 (MEM_LATENCY=2).
//      Required: epc_out=0x3C with epc_wr in cycle 1; addr_sel=101 in cycles 1-2;
//      pc_out=0x80 with pc_wr=done=1 in cycle 3.
//   3. Causes 0 and 2 -> addr_sel 100 and 110 respectively; mem_data=0xFFFF_FF12 -> pc_out=0x12.
//   4. cause=3 -> no state change, busy stays 0. Second exc_req during ADDR -> ignored, exactly one pc_wr.
//   5. pc_in=0x0 -> epc_out=0xFFFF_FFFC (wrap).
//   6. MEM_LATENCY=1 build: pc_wr in cycle 2, addr_sel_valid for exactly one cycle.
//      Randomized requests: every accepted request yields exactly one epc_wr and one pc_wr.

Source files
------------

// File: rtl/exception_vector_fetch.sv
// -----------------------------------------------------------------------------
// exception_vector_fetch
//   Consumer side of the memory-address exception path. When an exception is
//   accepted it saves EPC, steers the memory-address mux to the vector byte
//   for the cause (253/254/255) and holds it there for MEM_LATENCY cycles.
//   It then loads the zero-extended handler byte from memory into PC.
//
// Parameters
//   MEM_LATENCY    cycles the vector address is held before mem_data is
//                  sampled (legal 1..15)
//   EPC_OFFSET     subtracted from pc_in to form EPC (pc_in is already PC+4)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   exc_req        exception request (pulse or level), sampled only in IDLE
//   exc_cause      0=invalid opcode, 1=overflow, 2=div by zero, 3=reserved
//   pc_in          PC+4 of the faulting instruction
//   mem_data       memory read data, handler address in bits [7:0]
//   addr_sel       address mux select: 100=253, 101=254, 110=255
//   addr_sel_valid control must route addr_sel to the mux, mem write off
//   epc_out        value to write to EPC
//   epc_wr         one-cycle EPC write strobe
//   pc_out         handler address {24'b0, mem_data[7:0]}
//   pc_wr          one-cycle PC write strobe
//   busy           high while not IDLE
//   done           one-cycle pulse coincident with pc_wr
// -----------------------------------------------------------------------------
module exception_vector_fetch #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data,
    output logic [2:0]  addr_sel,
    output logic        addr_sel_valid,
    output logic [31:0] epc_out,
    output logic        epc_wr,
    output logic [31:0] pc_out,
    output logic        pc_wr,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ADDR   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // Counter start value: the last ADDR cycle is the one where cnt reaches 0.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 32'd1);

    // Vector-byte mux select for each cause; reserved cause maps to "no select".
    function automatic logic [2:0] cause_to_sel(input logic [1:0] cause);
        logic [2:0] sel;
        case (cause)
            2'd0:    sel = 3'b100;
            2'd1:    sel = 3'b101;
            2'd2:    sel = 3'b110;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    logic [1:0]  state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [2:0]  sel_r, sel_s;
    logic        valid_r, valid_s;
    logic [31:0] epc_r, epc_s;
    logic        epc_wr_r, epc_wr_s;
    logic [31:0] pc_r, pc_s;
    logic        pc_wr_r, pc_wr_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    // Only the handler byte is meaningful; the upper read-data bits are dropped.
    logic unused_mem_s;
    assign unused_mem_s = ^mem_data[31:8];

    // Next-state and next-output computation for the vector fetch sequence.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        sel_s    = sel_r;
        valid_s  = valid_r;
        epc_s    = epc_r;
        epc_wr_s = 1'b0;
        pc_s     = pc_r;
        pc_wr_s  = 1'b0;
        busy_s   = busy_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (exc_req && (exc_cause != 2'd3)) begin
                    state_s  = ADDR;
                    cnt_s    = CNT_LOAD;
                    epc_s    = pc_in - EPC_OFFSET;
                    epc_wr_s = 1'b1;
                    sel_s    = cause_to_sel(exc_cause);
                    valid_s  = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            ADDR: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    // Address has been held long enough: memory data is valid now.
                    pc_s    = {24'd0, mem_data[7:0]};
                    pc_wr_s = 1'b1;
                    done_s  = 1'b1;
                    valid_s = 1'b0;
                    sel_s   = 3'b000;
                    state_s = COMMIT;
                end
            end
            COMMIT: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
                sel_s   = 3'b000;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous abort on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            sel_r    <= 3'b000;
            valid_r  <= 1'b0;
            epc_r    <= 32'd0;
            epc_wr_r <= 1'b0;
            pc_r     <= 32'd0;
            pc_wr_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            sel_r    <= sel_s;
            valid_r  <= valid_s;
            epc_r    <= epc_s;
            epc_wr_r <= epc_wr_s;
            pc_r     <= pc_s;
            pc_wr_r  <= pc_wr_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign addr_sel       = sel_r;
    assign addr_sel_valid = valid_r;
    assign epc_out        = epc_r;
    assign epc_wr         = epc_wr_r;
    assign pc_out         = pc_r;
    assign pc_wr          = pc_wr_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_exception_vector_fetch.sv
// -----------------------------------------------------------------------------
// tb_exception_vector_fetch
//   Directed bench for exception_vector_fetch. One instance uses the default
//   MEM_LATENCY=2, a second uses MEM_LATENCY=1. Expected values are written
//   out by hand; the MEM_LATENCY=1 instance also gets a random request stream
//   checked against a small acceptance model.
// -----------------------------------------------------------------------------
module tb_exception_vector_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // MEM_LATENCY=2 instance
    logic        exc_req = 1'b0;
    logic [1:0]  exc_cause = 2'd0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic [2:0]  addr_sel;
    logic        addr_sel_valid;
    logic [31:0] epc_out;
    logic        epc_wr;
    logic [31:0] pc_out;
    logic        pc_wr;
    logic        busy;
    logic        done;

    // MEM_LATENCY=1 instance
    logic        exc_req1 = 1'b0;
    logic [1:0]  exc_cause1 = 2'd0;
    logic [31:0] pc_in1 = 32'd0;
    logic [31:0] mem_data1 = 32'd0;
    logic [2:0]  addr_sel1;
    logic        addr_sel_valid1;
    logic [31:0] epc_out1;
    logic        epc_wr1;
    logic [31:0] pc_out1;
    logic        pc_wr1;
    logic        busy1;
    logic        done1;

    int total = 0;
    int bad   = 0;
    int n_epc  = 0;
    int n_pc   = 0;
    int n_epc1 = 0;
    int n_pc1  = 0;

    always #5 clk = ~clk;

    exception_vector_fetch #(.MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .exc_req(exc_req), .exc_cause(exc_cause),
        .pc_in(pc_in), .mem_data(mem_data), .addr_sel(addr_sel),
        .addr_sel_valid(addr_sel_valid), .epc_out(epc_out), .epc_wr(epc_wr),
        .pc_out(pc_out), .pc_wr(pc_wr), .busy(busy), .done(done)
    );

    exception_vector_fetch #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .exc_req(exc_req1), .exc_cause(exc_cause1),
        .pc_in(pc_in1), .mem_data(mem_data1), .addr_sel(addr_sel1),
        .addr_sel_valid(addr_sel_valid1), .epc_out(epc_out1), .epc_wr(epc_wr1),
        .pc_out(pc_out1), .pc_wr(pc_wr1), .busy(busy1), .done(done1)
    );

    // Strobe counters: registered outputs seen at each rising edge.
    always @(posedge clk) begin
        if (epc_wr)  n_epc  <= n_epc + 1;
        if (pc_wr)   n_pc   <= n_pc + 1;
        if (epc_wr1) n_epc1 <= n_epc1 + 1;
        if (pc_wr1)  n_pc1  <= n_pc1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full exception on the MEM_LATENCY=2 instance. With hold set, the
    // request stays high and cause/pc_in change while busy; none of it may matter.
    task automatic run_exc(input logic [1:0] cause, input logic [31:0] pc,
                           input logic [31:0] mem, input logic [2:0] exp_sel,
                           input logic [31:0] exp_epc, input logic [31:0] exp_pc,
                           input bit hold);
        int p0;
        p0 = n_pc;
        exc_req = 1'b1; exc_cause = cause; pc_in = pc; mem_data = mem;
        tick();  // cycle 1
        chk("c1_epc", epc_out, exp_epc);
        chk("c1_epc_wr", {31'd0, epc_wr}, 32'd1);
        chk("c1_sel", {29'd0, addr_sel}, {29'd0, exp_sel});
        chk("c1_valid", {31'd0, addr_sel_valid}, 32'd1);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        chk("c1_pc_wr", {31'd0, pc_wr}, 32'd0);
        if (hold) begin
            exc_cause = 2'd0; pc_in = 32'h0000_0999;
        end else begin
            exc_req = 1'b0;
        end
        tick();  // cycle 2
        chk("c2_epc_wr", {31'd0, epc_wr}, 32'd0);
        chk("c2_sel", {29'd0, addr_sel}, {29'd0, exp_sel});
        chk("c2_valid", {31'd0, addr_sel_valid}, 32'd1);
        chk("c2_pc_wr", {31'd0, pc_wr}, 32'd0);
        tick();  // cycle 3
        exc_req = 1'b0;
        chk("c3_pc", pc_out, exp_pc);
        chk("c3_pc_wr", {31'd0, pc_wr}, 32'd1);
        chk("c3_done", {31'd0, done}, 32'd1);
        chk("c3_valid", {31'd0, addr_sel_valid}, 32'd0);
        chk("c3_sel", {29'd0, addr_sel}, 32'd0);
        chk("c3_epc_hold", epc_out, exp_epc);
        tick();  // cycle 4, back in IDLE
        chk("c4_pc_wr", {31'd0, pc_wr}, 32'd0);
        chk("c4_done", {31'd0, done}, 32'd0);
        chk("c4_busy", {31'd0, busy}, 32'd0);
        chk("c4_pc_hold", pc_out, exp_pc);
        chk("one_pc_wr", n_pc - p0, 32'd1);
    endtask

    initial begin
        int p0;
        int e1;
        int q1;
        int acc;
        int mbusy;

        // Reset held, then released.
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_outs", {addr_sel, addr_sel_valid, epc_wr, pc_wr, done}, 32'd0);
        chk("rel_epc", epc_out, 32'd0);
        chk("rel_pc", pc_out, 32'd0);

        // Overflow example, then causes 0 and 2, wrap, and the held-request case.
        run_exc(2'd1, 32'h0000_0040, 32'h0000_0080, 3'b101, 32'h0000_003C, 32'h0000_0080, 1'b0);
        run_exc(2'd0, 32'h0000_0000, 32'hFFFF_FF12, 3'b100, 32'hFFFF_FFFC, 32'h0000_0012, 1'b0);
        run_exc(2'd2, 32'h0000_0100, 32'hFFFF_FF12, 3'b110, 32'h0000_00FC, 32'h0000_0012, 1'b0);
        run_exc(2'd1, 32'h1234_5678, 32'h0000_00A5, 3'b101, 32'h1234_5674, 32'h0000_00A5, 1'b1);

        // Reserved cause: no acceptance, no strobes.
        p0 = n_epc;
        exc_req = 1'b1; exc_cause = 2'd3; pc_in = 32'h0000_0200;
        tick();
        chk("c3_busy", {31'd0, busy}, 32'd0);
        chk("c3_valid0", {31'd0, addr_sel_valid}, 32'd0);
        tick();
        exc_req = 1'b0;
        chk("c3_no_epc", n_epc - p0, 32'd0);
        chk("c3_epc_kept", epc_out, 32'h1234_5674);

        // Reset mid-ADDR aborts at once and never produces pc_wr.
        p0 = n_pc;
        exc_req = 1'b1; exc_cause = 2'd2; pc_in = 32'h0000_0300; mem_data = 32'h55;
        tick();
        chk("ab_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ab_busy0", {31'd0, busy}, 32'd0);
        chk("ab_outs", {addr_sel, addr_sel_valid, epc_wr, pc_wr, done}, 32'd0);
        chk("ab_epc", epc_out, 32'd0);
        exc_req = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        chk("ab_no_pc_wr", n_pc - p0, 32'd0);
        chk("ab_pc", pc_out, 32'd0);

        // MEM_LATENCY=1: pc_wr in cycle 2, select valid for one cycle.
        exc_req1 = 1'b1; exc_cause1 = 2'd1; pc_in1 = 32'h0000_0040; mem_data1 = 32'h0000_0080;
        tick();
        exc_req1 = 1'b0;
        chk("l1_c1_valid", {31'd0, addr_sel_valid1}, 32'd1);
        chk("l1_c1_sel", {29'd0, addr_sel1}, 32'd5);
        chk("l1_c1_epc", epc_out1, 32'h0000_003C);
        chk("l1_c1_pc_wr", {31'd0, pc_wr1}, 32'd0);
        tick();
        chk("l1_c2_pc_wr", {31'd0, pc_wr1}, 32'd1);
        chk("l1_c2_done", {31'd0, done1}, 32'd1);
        chk("l1_c2_valid", {31'd0, addr_sel_valid1}, 32'd0);
        chk("l1_c2_pc", pc_out1, 32'h0000_0080);
        tick();
        chk("l1_c3_busy", {31'd0, busy1}, 32'd0);

        // Random stream on MEM_LATENCY=1: accepted only in IDLE with cause != 3,
        // after which the block is busy for two edges.
        e1 = n_epc1; q1 = n_pc1; acc = 0; mbusy = 0;
        for (int i = 0; i < 200; i++) begin
            exc_req1   = 1'($urandom_range(0, 1));
            exc_cause1 = 2'($urandom_range(0, 3));
            pc_in1     = $urandom;
            mem_data1  = $urandom;
            if (mbusy == 0 && exc_req1 && exc_cause1 != 2'd3) begin
                acc++;
                mbusy = 2;
            end else if (mbusy > 0) begin
                mbusy--;
            end
            tick();
            chk("rnd_busy", {31'd0, busy1}, {31'd0, (mbusy != 0)});
        end
        exc_req1 = 1'b0;
        tick(); tick(); tick();
        chk("rnd_epc_cnt", n_epc1 - e1, acc);
        chk("rnd_pc_cnt", n_pc1 - q1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
